gshare_predictor: RTL

- Branch direction and target predictor for the fetch stage of the pipelined RV32I core.
- Direction: gshare, a 2-bit-counter pattern history table (PHT) indexed by PC XOR global history register (BHR).
- Target: a direct-mapped branch target buffer (BTB).
- Fetch queries it each cycle. Execute returns resolved outcomes plus the BHR snapshot carried in predict_regs.
- Also keeps the branch_total, branch_correct and branch_incorrect performance counters.

---
 rtl/gshare_if.sv | 38 +++
 rtl/gshare_predictor.sv | 125 ++++++++++++
 2 files changed

// File: rtl/gshare_if.sv
// Fetch/execute-facing bundle of the gshare branch predictor.
// Handshake: no ready. A lookup is taken when req_valid=1 and stall=0; an update is always taken when upd_valid=1.
interface gshare_if #(
  parameter int BHR_WIDTH = 5
);
  logic                 req_valid;
  logic [31:0]          req_pc;
  logic                 stall;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic [BHR_WIDTH-1:0] pred_bhr;
  logic [31:0]          pred_btb_address;
  logic                 upd_valid;
  logic [31:0]          upd_pc;
  logic                 upd_is_cond;
  logic                 upd_taken;
  logic [31:0]          upd_target;
  logic [BHR_WIDTH-1:0] upd_bhr;
  logic                 upd_mispredict;
  logic [31:0]          cnt_total;
  logic [31:0]          cnt_correct;
  logic [31:0]          cnt_incorrect;

  modport master (
    output req_valid, req_pc, stall,
    output upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, upd_bhr, upd_mispredict,
    input  pred_valid, pred_taken, pred_target, pred_bhr, pred_btb_address,
    input  cnt_total, cnt_correct, cnt_incorrect
  );

  modport slave (
    input  req_valid, req_pc, stall,
    input  upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, upd_bhr, upd_mispredict,
    output pred_valid, pred_taken, pred_target, pred_bhr, pred_btb_address,
    output cnt_total, cnt_correct, cnt_incorrect
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor with a direct-mapped BTB and branch performance counters.
// Lookups read pre-update tables; misprediction repair of the history wins over speculation.
module gshare_predictor #(
  parameter int BHR_WIDTH = 5,
  parameter int BTB_IDX   = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  gshare_if.slave  bus
);
  localparam int PHT_N = 1 << BHR_WIDTH;
  localparam int BTB_N = 1 << BTB_IDX;
  localparam int TAG_W = 32 - BTB_IDX - 2;

  logic [1:0]           pht [PHT_N];
  logic [BTB_N-1:0]     btb_valid;
  logic [BTB_N-1:0]     btb_cond;
  logic [TAG_W-1:0]     btb_tag [BTB_N];
  logic [31:0]          btb_target [BTB_N];
  logic [BHR_WIDTH-1:0] bhr;

  logic [BTB_IDX-1:0]   lk_idx;
  logic [BHR_WIDTH-1:0] lk_pht_idx;
  logic                 lk_hit;
  logic                 lk_cond;
  logic                 lk_taken;
  logic [31:0]          lk_target;
  logic                 accept;

  logic [BTB_IDX-1:0]   up_idx;
  logic [BHR_WIDTH-1:0] up_pht_idx;
  logic [1:0]           up_old;
  logic [1:0]           up_new;
  logic                 unused_bits;

  assign unused_bits = ^bus.upd_pc[1:0];

  always_comb begin
    accept     = bus.req_valid && !bus.stall;
    lk_idx     = bus.req_pc[BTB_IDX+1:2];
    lk_pht_idx = bus.req_pc[BHR_WIDTH+1:2] ^ bhr;
    lk_hit     = btb_valid[lk_idx] && (btb_tag[lk_idx] == bus.req_pc[31:BTB_IDX+2]);
    lk_cond    = btb_cond[lk_idx];
    lk_taken   = lk_hit && (!lk_cond || pht[lk_pht_idx][1]);
    lk_target  = lk_taken ? btb_target[lk_idx] : bus.req_pc + 32'd4;
  end

  always_comb begin
    up_idx     = bus.upd_pc[BTB_IDX+1:2];
    up_pht_idx = bus.upd_pc[BHR_WIDTH+1:2] ^ bus.upd_bhr;
    up_old     = pht[up_pht_idx];
    up_new     = up_old;
    if (bus.upd_taken) begin
      if (up_old != 2'b11) up_new = up_old + 2'd1;
    end else begin
      if (up_old != 2'b00) up_new = up_old - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (bus.upd_valid && bus.upd_is_cond) begin
      pht[up_pht_idx] <= up_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btb_valid <= '0;
      btb_cond  <= '0;
    end else if (bus.upd_valid && bus.upd_taken) begin
      btb_valid[up_idx] <= 1'b1;
      btb_cond[up_idx]  <= bus.upd_is_cond;
    end
  end

  // Tag and target payload are qualified by btb_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (bus.upd_valid && bus.upd_taken) begin
      btb_tag[up_idx]    <= bus.upd_pc[31:BTB_IDX+2];
      btb_target[up_idx] <= bus.upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bhr <= '0;
    end else if (bus.upd_valid && bus.upd_mispredict) begin
      bhr <= bus.upd_is_cond ? {bus.upd_bhr[BHR_WIDTH-2:0], bus.upd_taken} : bus.upd_bhr;
    end else if (accept && lk_hit && lk_cond) begin
      bhr <= {bhr[BHR_WIDTH-2:0], lk_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.pred_valid       <= 1'b0;
      bus.pred_taken       <= 1'b0;
      bus.pred_target      <= '0;
      bus.pred_bhr         <= '0;
      bus.pred_btb_address <= '0;
    end else if (!bus.stall) begin
      bus.pred_valid <= bus.req_valid;
      if (bus.req_valid) begin
        bus.pred_taken       <= lk_taken;
        bus.pred_target      <= lk_target;
        bus.pred_bhr         <= bhr;
        bus.pred_btb_address <= lk_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cnt_total     <= '0;
      bus.cnt_correct   <= '0;
      bus.cnt_incorrect <= '0;
    end else if (bus.upd_valid && bus.upd_is_cond) begin
      bus.cnt_total <= bus.cnt_total + 32'd1;
      if (bus.upd_mispredict) bus.cnt_incorrect <= bus.cnt_incorrect + 32'd1;
      else                    bus.cnt_correct   <= bus.cnt_correct + 32'd1;
    end
  end
endmodule
